// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 exception/interrupt controller.
// Provides register indices, exception codes, fixed addresses, bit positions
// of the implemented SR/Cause fields, and the EPC capture helper.
package cp0_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned EXC_W   = 5;
  localparam int unsigned HWINT_W = 6;

  // CP0 register indices
  localparam logic [ADDR_W-1:0] REG_SR    = 5'd12;
  localparam logic [ADDR_W-1:0] REG_CAUSE = 5'd13;
  localparam logic [ADDR_W-1:0] REG_EPC   = 5'd14;
  localparam logic [ADDR_W-1:0] REG_PRID  = 5'd15;

  // Exception codes
  localparam logic [EXC_W-1:0] EXC_INT     = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL    = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES    = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYSCALL = 5'd8;
  localparam logic [EXC_W-1:0] EXC_RI      = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV      = 5'd12;

  // Fixed addresses
  localparam logic [DATA_W-1:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [DATA_W-1:0] RESET_PC     = 32'h0000_3000;

  // Bit positions of implemented fields
  localparam int unsigned IM_LSB  = 10;
  localparam int unsigned IM_MSB  = 15;
  localparam int unsigned EXL_BIT = 1;
  localparam int unsigned IE_BIT  = 0;
  localparam int unsigned BD_BIT  = 31;
  localparam int unsigned IP_LSB  = 10;
  localparam int unsigned IP_MSB  = 15;
  localparam int unsigned EXC_LSB = 2;
  localparam int unsigned EXC_MSB = 6;

  // Return address for a trapped instruction: back up to the branch when the
  // victim sits in a delay slot, and keep the result word aligned.
  function automatic logic [DATA_W-1:0] epc_target(input logic [DATA_W-1:0] vpc,
                                                   input logic              bd);
    logic [DATA_W-1:0] pc;
    pc = bd ? (vpc - 32'd4) : vpc;
    return {pc[DATA_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 exception/interrupt controller, sitting at the M stage.
// Decides whether the M-stage instruction traps (exception or interrupt),
// records the trap in SR/Cause/EPC and serves mfc0/mtc0/eret.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   en, CP0Add, CP0In   mtc0 strobe, register index, write data
//   VPC, BDIn           PC of the M-stage instruction and its delay-slot flag
//   ExcCodeIn           M-stage exception code (0 = none)
//   HWInt               level-sensitive hardware interrupt lines
//   EXLClr              eret in M stage
//   CP0Out              mfc0 read data (combinational on CP0Add)
//   EPCOut              EPC register value (eret target)
//   Req                 trap taken this cycle (combinational)
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [DATA_W-1:0] PRID_VAL = 32'h2023_0007
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [ADDR_W-1:0]   CP0Add,
  input  logic [DATA_W-1:0]   CP0In,
  input  logic [DATA_W-1:0]   VPC,
  input  logic                BDIn,
  input  logic [EXC_W-1:0]    ExcCodeIn,
  input  logic [HWINT_W-1:0]  HWInt,
  input  logic                EXLClr,
  output logic [DATA_W-1:0]   CP0Out,
  output logic [DATA_W-1:0]   EPCOut,
  output logic                Req
);

  logic [HWINT_W-1:0] im_q, im_d;
  logic               exl_q, exl_d;
  logic               ie_q, ie_d;
  logic               bd_q, bd_d;
  logic [HWINT_W-1:0] ip_q, ip_d;
  logic [EXC_W-1:0]   exc_q, exc_d;
  logic [DATA_W-1:0]  epc_q, epc_d;

  logic int_req;
  logic exc_req;

  // Trap request; EXL masks both sources, interrupt has priority
  always_comb begin
    int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    exc_req = (ExcCodeIn != EXC_INT) & ~exl_q;
    Req     = (int_req | exc_req) & ~reset;
  end

  // Next-state: a trap overrides mtc0 and eret in the same cycle
  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    ip_d  = HWInt;

    if (Req) begin
      exl_d = 1'b1;
      bd_d  = BDIn;
      exc_d = int_req ? EXC_INT : ExcCodeIn;
      epc_d = epc_target(VPC, BDIn);
    end else begin
      if (en) begin
        if (CP0Add == REG_SR) begin
          im_d  = CP0In[IM_MSB:IM_LSB];
          exl_d = CP0In[EXL_BIT];
          ie_d  = CP0In[IE_BIT];
        end else if (CP0Add == REG_EPC) begin
          epc_d = CP0In;
        end
      end
      // eret applied after mtc0 so a same-cycle SR write cannot re-set EXL
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  // mfc0 read mux; unimplemented bits and indices read 0
  always_comb begin
    CP0Out = '0;
    unique case (CP0Add)
      REG_SR: begin
        CP0Out[IM_MSB:IM_LSB] = im_q;
        CP0Out[EXL_BIT]       = exl_q;
        CP0Out[IE_BIT]        = ie_q;
      end
      REG_CAUSE: begin
        CP0Out[BD_BIT]          = bd_q;
        CP0Out[IP_MSB:IP_LSB]   = ip_q;
        CP0Out[EXC_MSB:EXC_LSB] = exc_q;
      end
      REG_EPC:  CP0Out = epc_q;
      REG_PRID: CP0Out = PRID_VAL;
      default:  CP0Out = '0;
    endcase
  end

  assign EPCOut = epc_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios followed by random
// traffic compared against a word-level model of SR, Cause and EPC.
module tb_cp0_ctrl;

  localparam logic [31:0] PRID = 32'h2023_0007;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  int checks;
  int failures;

  // Model state as architectural 32-bit words
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  cp0_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .CP0Add    (CP0Add),
    .CP0In     (CP0In),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .CP0Out    (CP0Out),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_int();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    logic exc;
    exc = (ExcCodeIn != 5'd0) && !m_sr[1];
    return (m_int() || exc) && !reset;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_update();
    logic [31:0] pc;
    if (m_req()) begin
      pc          = BDIn ? VPC - 32'd4 : VPC;
      m_epc       = pc & ~32'd3;
      m_cause     = 32'd0;
      m_cause[31] = BDIn;
      m_cause[6:2] = m_int() ? 5'd0 : ExcCodeIn;
      m_sr[1]     = 1'b1;
    end else begin
      if (en && CP0Add == 5'd12) m_sr = CP0In & 32'h0000_FC03;
      if (en && CP0Add == 5'd14) m_epc = CP0In;
      if (EXLClr) m_sr[1] = 1'b0;
    end
    m_cause[15:10] = HWInt;
  endtask

  // One clock: check outputs against the model, then advance both
  task automatic cycle(input string tag);
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end
    #1;
    chk({tag, " Req"}, {31'd0, Req}, {31'd0, m_req()});
    chk({tag, " CP0Out"}, CP0Out, m_read(CP0Add));
    chk({tag, " EPCOut"}, EPCOut, m_epc);
    if (!reset) m_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    checks = 0; failures = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    reset = 1'b1; en = 1'b0; CP0Add = 5'd12; CP0In = 32'd0; VPC = 32'h3000;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk("reset Req", {31'd0, Req}, 32'd0);
    chk("reset EPCOut", EPCOut, 32'd0);
    chk("reset SR", CP0Out, 32'd0);
    CP0Add = 5'd13; #1;
    chk("reset Cause", CP0Out, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Interrupt
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
    cycle("mtc0 SR");
    en = 1'b0; HWInt = 6'b000001; VPC = 32'h3010; BDIn = 1'b0;
    #1; chk("int Req", {31'd0, Req}, 32'd1);
    cycle("int take");
    CP0Add = 5'd13; #1;
    chk("int Req after", {31'd0, Req}, 32'd0);
    chk("int Cause", CP0Out, 32'h0000_0400);
    chk("int EPC", EPCOut, 32'h0000_3010);
    CP0Add = 5'd12; #1;
    chk("int SR EXL", CP0Out, 32'h0000_0403);
    HWInt = 6'd0; EXLClr = 1'b1;
    cycle("eret 1");
    EXLClr = 1'b0;

    // Exception in delay slot
    ExcCodeIn = 5'd12; BDIn = 1'b1; VPC = 32'h3024; CP0Add = 5'd13;
    #1; chk("ov Req", {31'd0, Req}, 32'd1);
    cycle("ov take");
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    #1;
    chk("ov Cause", CP0Out, 32'h8000_0030);
    chk("ov EPC", EPCOut, 32'h0000_3020);
    EXLClr = 1'b1;
    cycle("eret 2");
    EXLClr = 1'b0;

    // Interrupt and exception together: interrupt wins
    HWInt = 6'b000001; ExcCodeIn = 5'd10; VPC = 32'h3030;
    #1; chk("both Req", {31'd0, Req}, 32'd1);
    cycle("both take");
    ExcCodeIn = 5'd0;
    #1; chk("both Cause", CP0Out, 32'h0000_0400);
    HWInt = 6'd0; EXLClr = 1'b1;
    cycle("eret 3");
    EXLClr = 1'b0;

    // Trap beats a same-cycle mtc0 to EPC
    ExcCodeIn = 5'd8; en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_5555; VPC = 32'h3040;
    #1; chk("sys Req", {31'd0, Req}, 32'd1);
    cycle("sys take");
    en = 1'b0; ExcCodeIn = 5'd0;
    #1; chk("sys EPC", EPCOut, 32'h0000_3040);

    // Masked exception while EXL = 1
    ExcCodeIn = 5'd4; CP0Add = 5'd13;
    #1; chk("mask Req", {31'd0, Req}, 32'd0);
    cycle("mask");
    ExcCodeIn = 5'd0;
    #1;
    chk("mask Cause", CP0Out, 32'h0000_0020);
    chk("mask EPC", EPCOut, 32'h0000_3040);

    // eret with a pending interrupt: Req in the following cycle
    HWInt = 6'b000001; EXLClr = 1'b1; VPC = 32'h3050;
    #1; chk("eret Req same", {31'd0, Req}, 32'd0);
    cycle("eret pend");
    EXLClr = 1'b0;
    #1; chk("eret Req next", {31'd0, Req}, 32'd1);
    cycle("eret int");

    // Asynchronous reset mid-cycle with EXL = 1
    CP0Add = 5'd12;
    #2; chk("pre-reset SR", CP0Out, 32'h0000_0403);
    reset = 1'b1;
    m_sr = 0; m_cause = 0; m_epc = 0;
    #1;
    chk("async Req", {31'd0, Req}, 32'd0);
    chk("async EPC", EPCOut, 32'd0);
    chk("async SR", CP0Out, 32'd0);
    @(negedge clk);
    reset = 1'b0; HWInt = 6'd0; CP0Add = 5'd15;
    cycle("prid");
    CP0Add = 5'd20; #1;
    chk("unimpl read", CP0Out, 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 49) == 0);
      en     = ($urandom_range(0, 2) == 0);
      EXLClr = ($urandom_range(0, 3) == 0);
      BDIn   = $urandom_range(0, 1) == 1;
      r = $urandom; VPC = r;
      r = $urandom; CP0In = r;
      case ($urandom_range(0, 5))
        0: CP0Add = 5'd12;
        1: CP0Add = 5'd13;
        2: CP0Add = 5'd14;
        3: CP0Add = 5'd15;
        default: CP0Add = 5'($urandom);
      endcase
      case ($urandom_range(0, 11))
        0: ExcCodeIn = 5'd4;
        1: ExcCodeIn = 5'd5;
        2: ExcCodeIn = 5'd8;
        3: ExcCodeIn = 5'd10;
        4: ExcCodeIn = 5'd12;
        default: ExcCodeIn = 5'd0;
      endcase
      HWInt = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      cycle("rand");
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
